pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/forwarding controller for the 5-stage pipeline; sequences the IF/ID and D/E pipeline registers.
//  Keeps a shadow copy of the E and M stage write-back info (wreg, m2reg, rn).
//  From it, generates: forwarding selects, load-use stalls, bubbles into D/E, IF/ID flush on taken branch.
//  Also runs a multi-cycle mul/div busy FSM that holds the front end until the result is ready.
// PARAMETERS
//  MDIV_CYCLES  8  execute latency of a mul/div op in cycles; legal range 2..15
//  CNT_W        4  busy-counter width; must hold MDIV_CYCLES-1
// PORTS
//  clock    in   1  pipeline clock, rising edge
//  resetn   in   1  asynchronous reset, active low
//  drs      in   5  decode-stage rs field
//  drt      in   5  decode-stage rt field
//  duse_rs  in   1  decode instruction reads rs
//  duse_rt  in   1  decode instruction reads rt (ALU operand or store data)
//  dwreg    in   1  decode instruction writes the register file
//  dm2reg   in   1  decode instruction is a load
//  drn      in   5  decode destination register
//  dmdiv    in   1  decode instruction is a multi-cycle mul/div
//  dbranch  in   1  branch/jump taken, resolved in decode
//  wpcir    out  1  write enable for PC and IF/ID; 0 = hold
//  dbubble  out  1  1 = D/E register loads zeroed controls (wreg/m2reg/wmem = 0)
//  dflush   out  1  1 = IF/ID loads a NOP (kills the wrong-path fetch)
//  fwda     out  2  operand-A select: 00 regfile, 01 E ALU result, 10 M ALU result, 11 M load data
//  fwdb     out  2  operand-B select, same encoding, keyed on drt
//  md_busy  out  1  mul/div in progress
//  md_done  out  1  one-cycle pulse: mul/div result valid for write-back
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - Shadows ewreg/em2reg/ern/mwreg/mm2reg/mrn cleared; FSM = RUN; counter = 0.
//   - Outputs: wpcir=1, dbubble=0, dflush=0, fwda=fwdb=00, md_busy=0, md_done=0.
//  Shadow pipeline, each posedge:
//   - E <= (dbubble ? 0 : {dwreg,dm2reg,drn}); M <= E.
//   - All decisions below are combinational from the shadows and the d* inputs; no added latency.
//  Forwarding (fwda shown; fwdb identical with drt/duse_rt):
//   - Match E: ewreg & ern!=0 & ern==drs. Match M: mwreg & mrn!=0 & mrn==drs.
//   - E match with !em2reg -> 01.
//   - Else M match -> 10 if !mm2reg, 11 if mm2reg. Else 00.
//   - E has priority over M. Register 0 never forwards. fwd* is driven even when duse_* = 0.
//  Load-use stall (lds):
//   - ewreg & em2reg & ern!=0 & ((duse_rs & ern==drs) | (duse_rt & ern==drt)).
//   - lds -> wpcir=0, dbubble=1; exactly one cycle, because the load then moves to M and forwards via 11.
//  Branch flush: dflush = dbranch & !lds & state==RUN. A stalled branch is re-evaluated next cycle.
//  Mul/div FSM, states RUN, BUSY, DONE:
//   - RUN: if dmdiv & !lds, the op issues to E normally; next state BUSY, cnt <= MDIV_CYCLES-2.
//   - BUSY: wpcir=0, dbubble=1, dflush=0, md_busy=1; cnt decrements; at cnt==0 next state DONE.
//   - DONE: md_busy=1, md_done=1, wpcir=0, dbubble=1; next state RUN.
//   - Total front-end hold = MDIV_CYCLES cycles after the issue cycle.
//  Priority: reset > FSM BUSY/DONE > lds > dbranch.
//   - dmdiv with lds: stall only; mul/div starts on a later cycle.
//  Reset mid-BUSY aborts the op: FSM = RUN, md_done never pulses.
// TESTING
//  1 add r3,r1,r2 then sub r4,r3,r5: cycle 2 fwda=01; one cycle later, rs=r3 gives fwda=10; wpcir stays 1.
//  2 lw r3 then add r4,r3,r3: one cycle wpcir=0, dbubble=1; next cycle fwda=fwdb=11, wpcir=1.
//  3 lw r0 then use r0: no stall, fwda=00. lw r3 then add with duse_rt=0, drt=3: no stall.
//  4 dbranch=1 in RUN, no hazard: dflush=1 same cycle. Branch while lds: dflush=0 that cycle, 1 the next.
//  5 dmdiv=1, MDIV_CYCLES=8: md_busy high 8 cycles; md_done pulses in the 8th cycle; wpcir low 8 cycles, then 1.
//  6 resetn=0 asynchronously in the 3rd BUSY cycle: md_busy=0, wpcir=1, fwda=00 immediately; no md_done.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline: forwarding selects, load-use
// stalls, branch flush and a multi-cycle mul/div hold, all decided from an E/M shadow.

module pipe_hazard_fwd (
  input  logic       ewreg_i,
  input  logic       em2reg_i,
  input  logic [4:0] ern_i,
  input  logic       mwreg_i,
  input  logic       mm2reg_i,
  input  logic [4:0] mrn_i,
  input  logic [4:0] src_i,
  input  logic       use_i,
  output logic [1:0] fwd_o,
  output logic       lds_o
);
  logic e_hit, m_hit;

  assign e_hit = ewreg_i & (ern_i != 5'd0) & (ern_i == src_i);
  assign m_hit = mwreg_i & (mrn_i != 5'd0) & (mrn_i == src_i);

  // A load still in E cannot forward; it falls through to M (or to the stall).
  always_comb begin
    fwd_o = 2'b00;
    if (e_hit && !em2reg_i) fwd_o = 2'b01;
    else if (m_hit)         fwd_o = mm2reg_i ? 2'b11 : 2'b10;
  end

  assign lds_o = e_hit & em2reg_i & use_i;
endmodule

module pipe_hazard_ctrl #(
  parameter int MDIV_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] drs,
  input  logic [4:0] drt,
  input  logic       duse_rs,
  input  logic       duse_rt,
  input  logic       dwreg,
  input  logic       dm2reg,
  input  logic [4:0] drn,
  input  logic       dmdiv,
  input  logic       dbranch,
  output logic       wpcir,
  output logic       dbubble,
  output logic       dflush,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       md_busy,
  output logic       md_done
);
  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {S_RUN, S_BUSY, S_DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ewreg_q, em2reg_q, mwreg_q, mm2reg_q;
  logic [4:0]         ern_q, mrn_q;
  logic               ewreg_d, em2reg_d;
  logic [4:0]         ern_d;

  logic [NUM_OPS-1:0][4:0] src;
  logic [NUM_OPS-1:0]      use_src, lds_op;
  logic [NUM_OPS-1:0][1:0] fwd;
  logic                    lds, hold;

  assign src     = {drt, drs};
  assign use_src = {duse_rt, duse_rs};

  for (genvar l = 0; l < NUM_OPS; l++) begin : g_op
    pipe_hazard_fwd u_fwd (
      .ewreg_i  (ewreg_q),
      .em2reg_i (em2reg_q),
      .ern_i    (ern_q),
      .mwreg_i  (mwreg_q),
      .mm2reg_i (mm2reg_q),
      .mrn_i    (mrn_q),
      .src_i    (src[l]),
      .use_i    (use_src[l]),
      .fwd_o    (fwd[l]),
      .lds_o    (lds_op[l])
    );
  end

  assign fwda = fwd[0];
  assign fwdb = fwd[1];
  assign lds  = |lds_op;

  // Mul/div hold dominates the load-use stall; both freeze the front end.
  assign hold    = (state_q != S_RUN);
  assign md_busy = hold;
  assign md_done = (state_q == S_DONE);
  assign wpcir   = ~hold & ~lds;
  assign dbubble = hold | lds;
  assign dflush  = dbranch & ~lds & ~hold;

  always_comb begin
    ewreg_d  = dwreg;
    em2reg_d = dm2reg;
    ern_d    = drn;
    if (dbubble) begin
      ewreg_d  = 1'b0;
      em2reg_d = 1'b0;
      ern_d    = 5'd0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ewreg_q  <= 1'b0;
      em2reg_q <= 1'b0;
      ern_q    <= 5'd0;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mrn_q    <= 5'd0;
    end else begin
      ewreg_q  <= ewreg_d;
      em2reg_q <= em2reg_d;
      ern_q    <= ern_d;
      mwreg_q  <= ewreg_q;
      mm2reg_q <= em2reg_q;
      mrn_q    <= ern_q;
    end
  end

  // Issue cycle runs in RUN; BUSY spans MDIV_CYCLES-1 cycles, DONE one more.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_RUN: if (dmdiv && !lds) begin
          state_q <= S_BUSY;
          cnt_q   <= CNT_W'(MDIV_CYCLES - 2);
        end
        S_BUSY: begin
          if (cnt_q == '0) state_q <= S_DONE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_DONE:  state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a history-based reference model.

module tb_pipe_hazard_ctrl;
  localparam int MDIV = 8;

  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] drs, drt, drn;
  logic       duse_rs, duse_rt, dwreg, dm2reg, dmdiv, dbranch;
  logic       wpcir, dbubble, dflush, md_busy, md_done;
  logic [1:0] fwda, fwdb;

  int checks = 0;
  int failures = 0;

  // Model: the last two records that entered E, and front-end hold cycles left.
  logic       e_w, e_m, m_w, m_m;
  logic [4:0] e_rn, m_rn;
  int         hold_left;
  logic       x_lds, x_busy;

  pipe_hazard_ctrl #(.MDIV_CYCLES(MDIV), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn), .drs(drs), .drt(drt), .duse_rs(duse_rs),
    .duse_rt(duse_rt), .dwreg(dwreg), .dm2reg(dm2reg), .drn(drn), .dmdiv(dmdiv),
    .dbranch(dbranch), .wpcir(wpcir), .dbubble(dbubble), .dflush(dflush),
    .fwda(fwda), .fwdb(fwdb), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (e_w && e_rn != 0 && e_rn == r && !e_m) return 2'd1;
    if (m_w && m_rn != 0 && m_rn == r)         return m_m ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    e_w = 0; e_m = 0; e_rn = 0; m_w = 0; m_m = 0; m_rn = 0; hold_left = 0;
  endtask

  task automatic zero_inputs();
    drs = 0; drt = 0; drn = 0; duse_rs = 0; duse_rt = 0;
    dwreg = 0; dm2reg = 0; dmdiv = 0; dbranch = 0;
  endtask

  task automatic rand_inputs();
    drs = 5'($urandom_range(0, 3)); drt = 5'($urandom_range(0, 3));
    drn = 5'($urandom_range(0, 3));
    duse_rs = 1'($urandom_range(0, 1)); duse_rt = 1'($urandom_range(0, 1));
    dwreg   = ($urandom_range(0, 3) != 0); dm2reg = ($urandom_range(0, 2) == 0);
    dmdiv   = ($urandom_range(0, 11) == 0); dbranch = ($urandom_range(0, 3) == 0);
  endtask

  // Called at posedge+1 with inputs applied; checks, then advances one clock.
  task automatic run_cycle();
    logic bub;
    #2;
    x_lds  = e_w && e_m && e_rn != 0 &&
             ((duse_rs && e_rn == drs) || (duse_rt && e_rn == drt));
    x_busy = (hold_left > 0);
    bub    = x_busy || x_lds;
    chk("fwda",    8'(fwda),    8'(ref_fwd(drs)));
    chk("fwdb",    8'(fwdb),    8'(ref_fwd(drt)));
    chk("wpcir",   8'(wpcir),   8'(!bub));
    chk("dbubble", 8'(dbubble), 8'(bub));
    chk("dflush",  8'(dflush),  8'(dbranch && !bub));
    chk("md_busy", 8'(md_busy), 8'(x_busy));
    chk("md_done", 8'(md_done), 8'(hold_left == 1));
    @(posedge clock);
    m_w = e_w; m_m = e_m; m_rn = e_rn;
    if (bub) begin e_w = 0; e_m = 0; e_rn = 0; end
    else     begin e_w = dwreg; e_m = dm2reg; e_rn = drn; end
    if (x_busy)             hold_left--;
    else if (dmdiv && !x_lds) hold_left = MDIV;
    #1;
  endtask

  initial begin
    int guard;
    resetn = 1'b0;
    zero_inputs();
    model_clear();
    #3;
    chk("rst_wpcir",   8'(wpcir),   8'd1);
    chk("rst_dbubble", 8'(dbubble), 8'd0);
    chk("rst_dflush",  8'(dflush),  8'd0);
    chk("rst_fwda",    8'(fwda),    8'd0);
    chk("rst_fwdb",    8'(fwdb),    8'd0);
    chk("rst_md_busy", 8'(md_busy), 8'd0);
    chk("rst_md_done", 8'(md_done), 8'd0);
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      run_cycle();
    end

    // Drain any mul/div in flight, then abort a fresh one in its 3rd BUSY cycle.
    zero_inputs();
    guard = 0;
    while (hold_left != 0 && guard < 20) begin run_cycle(); guard++; end
    chk("drain_timeout", 8'(hold_left != 0), 8'd0);
    dmdiv = 1'b1; dwreg = 1'b1; drn = 5'd5;
    run_cycle();
    zero_inputs();
    drs = 5'd5; duse_rs = 1'b1;
    run_cycle();
    run_cycle();
    #1;
    chk("pre_abort_busy", 8'(md_busy), 8'd1);
    resetn = 1'b0;
    #1;
    chk("abort_md_busy", 8'(md_busy), 8'd0);
    chk("abort_wpcir",   8'(wpcir),   8'd1);
    chk("abort_fwda",    8'(fwda),    8'd0);
    chk("abort_dbubble", 8'(dbubble), 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_md_done", 8'(md_done), 8'd0);
    end
    zero_inputs();
    model_clear();
    resetn = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      chk("post_abort_no_done", 8'(md_done), 8'd0);
    end
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
